// File: rtl/twpm_wb_bridge.sv
// rtl/twpm_wb_bridge.sv - Wishbone slave bridging MCU to TPM buffer RAM and command registers.
// Optional: define TWPM_WB_IRQ_EN to register irq_pend and drive irq_o from it.
module twpm_wb_bridge #(
  parameter int unsigned RAM_AW   = 9,
  parameter logic [31:0] ID_VALUE = 32'h54504D31
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  input  logic [16:0]       WBs_ADR,
  input  logic              WBs_CYC,
  input  logic              WBs_STB,
  input  logic              WBs_WE,
  input  logic [3:0]        WBs_BYTE_STB,
  input  logic [31:0]       WBs_WR_DAT,
  output logic [31:0]       WBs_RD_DAT,
  output logic              WBs_ACK,
  input  logic              exec_i,
  input  logic              abort_i,
  output logic              complete_o,
  output logic [RAM_AW-1:0] ram_a,
  output logic [31:0]       ram_wd,
  output logic [3:0]        ram_wen,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  input  logic [31:0]       ram_rd,
  output logic              irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic        exec_m_q, exec_s_q, exec_p_q, abort_m_q, abort_s_q, abort_p_q;
  logic        cmd_pend_q, cmd_pend_d, complete_q, complete_d, irq_pend;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rd_dat_q, rd_dat_d, reg_rdata;
  logic        req, req_ram, req_reg, ctrl_wr, exec_rise, abort_rise;
  logic        unused_adr;

  assign unused_adr = ^{WBs_ADR[15:RAM_AW+2], WBs_ADR[1:0]};

  assign req        = (state_q == S_IDLE) & WBs_CYC & WBs_STB & ~WB_RST;
  assign req_ram    = req & ~WBs_ADR[16];
  assign req_reg    = req & WBs_ADR[16];
  assign ctrl_wr    = req_reg & WBs_WE & (WBs_ADR[3:2] == 2'd2) & WBs_BYTE_STB[0];
  assign exec_rise  = exec_s_q & ~exec_p_q;
  assign abort_rise = abort_s_q & ~abort_p_q;

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      {exec_m_q, exec_s_q, exec_p_q}    <= 3'b0;
      {abort_m_q, abort_s_q, abort_p_q} <= 3'b0;
    end else begin
      {exec_m_q, exec_s_q, exec_p_q}    <= {exec_i, exec_m_q, exec_s_q};
      {abort_m_q, abort_s_q, abort_p_q} <= {abort_i, abort_m_q, abort_s_q};
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req) state_d = (req_ram & ~WBs_WE) ? S_RD_WAIT : S_ACK;
      S_RD_WAIT: state_d = S_ACK;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    WBs_ACK    = (state_q == S_ACK);
    WBs_RD_DAT = WBs_ACK ? rd_dat_q : 32'b0;
    ram_wr_en  = req_ram & WBs_WE;
    ram_rd_en  = req_ram & ~WBs_WE;
    ram_wen    = ram_wr_en ? WBs_BYTE_STB : 4'b0;
  end

  assign ram_a  = WBs_ADR[RAM_AW+1:2];
  assign ram_wd = WBs_WR_DAT;

  always_comb begin
    reg_rdata = 32'b0;
    unique case (WBs_ADR[3:2])
      2'd0:    reg_rdata = ID_VALUE;
      2'd1:    reg_rdata = {28'b0, irq_pend, cmd_pend_q, abort_s_q, exec_s_q};
      2'd3:    reg_rdata = {16'b0, cnt_q};
      default: reg_rdata = 32'b0;
    endcase
  end

  // Register reads are captured at request; RAM data one cycle later in RD_WAIT.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (req)                         rd_dat_d = (WBs_ADR[16] & ~WBs_WE) ? reg_rdata : 32'b0;
    else if (state_q == S_RD_WAIT)   rd_dat_d = ram_rd;
  end

  always_comb begin
    cmd_pend_d = cmd_pend_q;
    if (exec_rise)                                  cmd_pend_d = 1'b1;
    else if (abort_rise | (ctrl_wr & WBs_WR_DAT[1])) cmd_pend_d = 1'b0;
    complete_d = complete_q;
    if (ctrl_wr & WBs_WR_DAT[0] & exec_s_q) complete_d = 1'b1;
    else if (~exec_s_q)                     complete_d = 1'b0;
    cnt_d = cnt_q + {15'b0, exec_rise};
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      rd_dat_q   <= 32'b0;
      cmd_pend_q <= 1'b0;
      complete_q <= 1'b0;
      cnt_q      <= 16'b0;
    end else begin
      rd_dat_q   <= rd_dat_d;
      cmd_pend_q <= cmd_pend_d;
      complete_q <= complete_d;
      cnt_q      <= cnt_d;
    end
  end

  assign complete_o = complete_q;

`ifdef TWPM_WB_IRQ_EN
  logic irq_pend_q;
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) irq_pend_q <= 1'b0;
    else        irq_pend_q <= cmd_pend_q;
  end
  assign irq_pend = irq_pend_q;
`else
  assign irq_pend = 1'b0;
`endif

  assign irq_o = irq_pend;
endmodule

// File: tb/tb_twpm_wb_bridge.sv
// tb/tb_twpm_wb_bridge.sv - Directed scoreboard bench for twpm_wb_bridge.
module tb_twpm_wb_bridge;
  logic        WB_CLK = 1'b0;
  logic        WB_RST;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC, WBs_STB, WBs_WE;
  logic [3:0]  WBs_BYTE_STB;
  logic [31:0] WBs_WR_DAT, WBs_RD_DAT;
  logic        WBs_ACK;
  logic        exec_i, abort_i, complete_o, irq_o;
  logic [8:0]  ram_a;
  logic [31:0] ram_wd, ram_rd;
  logic [3:0]  ram_wen;
  logic        ram_wr_en, ram_rd_en;

  int n_err = 0;
  int n_checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem [0:511];

`ifdef TWPM_WB_IRQ_EN
  localparam logic        IRQ_ON  = 1'b1;
  localparam logic [31:0] IRQ_BIT = 32'h8;
`else
  localparam logic        IRQ_ON  = 1'b0;
  localparam logic [31:0] IRQ_BIT = 32'h0;
`endif

  twpm_wb_bridge dut (
    .WB_CLK(WB_CLK), .WB_RST(WB_RST), .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC),
    .WBs_STB(WBs_STB), .WBs_WE(WBs_WE), .WBs_BYTE_STB(WBs_BYTE_STB),
    .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
    .exec_i(exec_i), .abort_i(abort_i), .complete_o(complete_o),
    .ram_a(ram_a), .ram_wd(ram_wd), .ram_wen(ram_wen), .ram_wr_en(ram_wr_en),
    .ram_rd_en(ram_rd_en), .ram_rd(ram_rd), .irq_o(irq_o)
  );

  always #5 WB_CLK = ~WB_CLK;

  always @(posedge WB_CLK) begin
    if (WB_RST) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hDEADBEEF;
    end else if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_wd[8*b +: 8];
    end
    if (ram_rd_en) ram_rd <= mem[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0;
    WBs_ADR = '0; WBs_BYTE_STB = '0; WBs_WR_DAT = '0;
  endtask

  // Starts at a negedge; request-cycle strobes sampled #1 after drive.
  task automatic wb(input string tag, input logic we, input logic [16:0] adr,
                    input logic [31:0] dat, input logic [3:0] be,
                    input logic [31:0] exp, input int lat,
                    output logic s_wr, output logic s_rd, output logic [8:0] s_a,
                    output logic [3:0] s_wen);
    int n;
    exp_q.push_back(exp);
    WBs_ADR = adr; WBs_WE = we; WBs_WR_DAT = dat; WBs_BYTE_STB = be;
    WBs_CYC = 1'b1; WBs_STB = 1'b1;
    #1;
    s_wr = ram_wr_en; s_rd = ram_rd_en; s_a = ram_a; s_wen = ram_wen;
    n = 0;
    do begin
      @(negedge WB_CLK);
      n++;
    end while (!WBs_ACK && n < 8);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_dat"}, WBs_RD_DAT, exp_q.pop_front());
    idle_bus();
    @(negedge WB_CLK);
    chk({tag, "_ack1"}, 32'(WBs_ACK), 32'd0);
  endtask

  initial begin
    logic       wr, rd;
    logic [8:0] a;
    logic [3:0] wen;

    idle_bus();
    exec_i = 1'b0; abort_i = 1'b0; WB_RST = 1'b1;
    repeat (3) @(negedge WB_CLK);
    chk("rst_ack",  32'(WBs_ACK), 32'd0);
    chk("rst_rdat", WBs_RD_DAT, 32'd0);
    chk("rst_wen",  32'({ram_wr_en, ram_rd_en, ram_wen}), 32'd0);
    chk("rst_cmp",  32'({complete_o, irq_o}), 32'd0);
    WB_RST = 1'b0;
    @(negedge WB_CLK);

    wb("id", 1'b0, 17'h10000, 32'h0, 4'hF, 32'h54504D31, 1, wr, rd, a, wen);
    wb("st0", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("cnt0", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("wr_id", 1'b1, 17'h10000, 32'h12345678, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("wr_cnt", 1'b1, 17'h1000C, 32'h00001234, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("id_again", 1'b0, 17'h10000, 32'h0, 4'hF, 32'h54504D31, 1, wr, rd, a, wen);
    wb("cnt_again", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);

    wb("ram_rd", 1'b0, 17'h00010, 32'h0, 4'hF, 32'hDEADBEEF, 2, wr, rd, a, wen);
    chk("ram_rd_strb", 32'({wr, rd}), 32'b01);
    chk("ram_rd_a", 32'(a), 32'd4);
    wb("ram_wr", 1'b1, 17'h00010, 32'hA5A50001, 4'b0011, 32'h0, 1, wr, rd, a, wen);
    chk("ram_wr_strb", 32'({wr, rd}), 32'b10);
    chk("ram_wr_a", 32'(a), 32'd4);
    chk("ram_wr_wen", 32'(wen), 32'b0011);
    wb("ram_wr0", 1'b1, 17'h00010, 32'hFFFFFFFF, 4'b0000, 32'h0, 1, wr, rd, a, wen);
    chk("ram_wr0_wen", 32'(wen), 32'd0);
    wb("ram_alias", 1'b0, 17'h00810, 32'h0, 4'hF, 32'hDEAD0001, 2, wr, rd, a, wen);
    chk("ram_alias_a", 32'(a), 32'd4);

    exec_i = 1'b1;
    repeat (4) @(negedge WB_CLK);
    chk("irq_on", 32'(irq_o), 32'(IRQ_ON));
    wb("st_exec", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h5 | IRQ_BIT, 1, wr, rd, a, wen);
    wb("cnt1", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h1, 1, wr, rd, a, wen);
    wb("ctl_cmp", 1'b1, 17'h10008, 32'h1, 4'h1, 32'h0, 1, wr, rd, a, wen);
    chk("complete_set", 32'(complete_o), 32'd1);
    exec_i = 1'b0;
    repeat (4) @(negedge WB_CLK);
    chk("complete_clr", 32'(complete_o), 32'd0);
    wb("ctl_cmp_noexec", 1'b1, 17'h10008, 32'h1, 4'h1, 32'h0, 1, wr, rd, a, wen);
    chk("complete_ignored", 32'(complete_o), 32'd0);
    wb("st_pend", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h4 | IRQ_BIT, 1, wr, rd, a, wen);
    wb("ctl_clr_be0", 1'b1, 17'h10008, 32'h2, 4'b1110, 32'h0, 1, wr, rd, a, wen);
    wb("st_still", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h4 | IRQ_BIT, 1, wr, rd, a, wen);
    wb("ctl_clr", 1'b1, 17'h10008, 32'h2, 4'h1, 32'h0, 1, wr, rd, a, wen);
    wb("st_clr", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);

    // Rising edge of exec_s lands on the same clock as the CONTROL clear.
    exec_i = 1'b1;
    repeat (2) @(negedge WB_CLK);
    wb("ctl_clr_race", 1'b1, 17'h10008, 32'h2, 4'h1, 32'h0, 1, wr, rd, a, wen);
    wb("st_race", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h5 | IRQ_BIT, 1, wr, rd, a, wen);
    abort_i = 1'b1;
    repeat (4) @(negedge WB_CLK);
    wb("st_abort", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h3, 1, wr, rd, a, wen);
    abort_i = 1'b0; exec_i = 1'b0;
    repeat (4) @(negedge WB_CLK);

    force dut.cnt_q = 16'hFFFF;
    @(negedge WB_CLK);
    release dut.cnt_q;
    wb("cnt_pre", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h0000FFFF, 1, wr, rd, a, wen);
    exec_i = 1'b1;
    repeat (4) @(negedge WB_CLK);
    exec_i = 1'b0;
    wb("cnt_wrap", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);
    repeat (4) @(negedge WB_CLK);

    WBs_ADR = 17'h00010; WBs_WE = 1'b0; WBs_BYTE_STB = 4'hF;
    WBs_CYC = 1'b1; WBs_STB = 1'b1;
    @(negedge WB_CLK);
    WB_RST = 1'b1;
    idle_bus();
    @(negedge WB_CLK);
    chk("rrst_ack", 32'(WBs_ACK), 32'd0);
    chk("rrst_rdat", WBs_RD_DAT, 32'd0);
    chk("rrst_outs", 32'({ram_wr_en, ram_rd_en, ram_wen, complete_o, irq_o}), 32'd0);
    WB_RST = 1'b0;
    @(negedge WB_CLK);
    chk("rrst_ack2", 32'(WBs_ACK), 32'd0);
    wb("rrst_st", 1'b0, 17'h10004, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("rrst_cnt", 1'b0, 17'h1000C, 32'h0, 4'hF, 32'h0, 1, wr, rd, a, wen);
    wb("rrst_rd", 1'b0, 17'h00010, 32'h0, 4'hF, 32'hDEADBEEF, 2, wr, rd, a, wen);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/twpm_wb_bridge.md
TWPM_WB_BRIDGE -- requirements
Module: twpm_wb_bridge

Interface
REQ-001 SHALL have parameter RAM_AW, default 9, meaning TPM buffer RAM word-address width.
REQ-002 SHALL have parameter ID_VALUE, default 32'h54504D31, meaning the constant read from the ID register.
REQ-003 SHALL have port WB_CLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port WB_RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have Wishbone slave ports: WBs_ADR in 17, byte address; WBs_CYC in 1; WBs_STB in 1; WBs_WE in 1; WBs_BYTE_STB in 4; WBs_WR_DAT in 32; WBs_RD_DAT out 32; WBs_ACK out 1.
REQ-006 SHALL have ports exec_i in 1 and abort_i in 1, both asynchronous, from the LPC-clock register block.
REQ-007 SHALL have port complete_o  out  1  command-complete handshake to the LPC-clock register block.
REQ-008 SHALL have RAM second-port ports: ram_a out RAM_AW; ram_wd out 32; ram_wen out 4, byte enables; ram_wr_en out 1; ram_rd_en out 1; ram_rd in 32, valid one cycle after ram_rd_en.
REQ-009 SHALL have port irq_o  out  1  command-pending interrupt to the MCU.

Function
REQ-010 exec_i and abort_i SHALL each pass a 2-flop synchronizer (exec_s, abort_s); rising edges are detected on the synchronized values.
REQ-011 A request SHALL be WBs_CYC & WBs_STB sampled in IDLE.
REQ-012 Address decode: WBs_ADR[16]=0 selects RAM with ram_a = WBs_ADR[RAM_AW+1:2], bits above ignored (aliased). WBs_ADR[16]=1 selects a register by WBs_ADR[3:2]: 0 ID, 1 STATUS, 2 CONTROL, 3 COUNT.
REQ-013 FSM states SHALL be IDLE, RD_WAIT and ACK; reset state IDLE.
REQ-014 Register access or RAM write SHALL go IDLE->ACK, with WBs_ACK high for exactly one cycle in ACK, i.e. one cycle after the request.
REQ-015 RAM write SHALL pulse ram_wr_en for one cycle in the request cycle, with ram_wd=WBs_WR_DAT and ram_wen=WBs_BYTE_STB; BYTE_STB=0 still SHALL be acknowledged.
REQ-016 RAM read SHALL pulse ram_rd_en in the request cycle and go IDLE->RD_WAIT->ACK, with WBs_RD_DAT = ram_rd captured in RD_WAIT; ACK occurs two cycles after the request.
REQ-017 ACK SHALL always return to IDLE, and a request present in the following cycle SHALL be treated as new.
REQ-018 WBs_RD_DAT SHALL be 0 outside ACK cycles and for writes.
REQ-019 STATUS SHALL read {28'b0, irq_pend, cmd_pend, abort_s, exec_s}.
REQ-020 cmd_pend SHALL set on an exec_s rising edge and clear on an abort_s rising edge or on a CONTROL write with bit1=1 and BYTE_STB[0]=1; set SHALL win over a simultaneous clear.
REQ-021 A CONTROL write with bit0=1 and BYTE_STB[0]=1 SHALL set complete_o; complete_o SHALL clear in the cycle after exec_s is sampled 0.
REQ-022 A CONTROL write with bit0=1 while exec_s=0 SHALL be ignored.
REQ-023 COUNT SHALL read {16'b0, cnt}, where cnt is 16 bits, increments on each exec_s rising edge, and wraps 0xFFFF->0x0000.
REQ-024 Writes to ID, STATUS and COUNT SHALL be acknowledged and have no effect.

Reset
REQ-025 WB_RST SHALL force, on the next edge: IDLE, WBs_ACK=0, WBs_RD_DAT=0, ram_wr_en=0, ram_rd_en=0, ram_wen=0, complete_o=0, cmd_pend=0, irq_pend=0, cnt=0, synchronizers=0.
REQ-026 A transaction in flight at reset SHALL be abandoned without ACK.

Configuration
REQ-027 With TWPM_WB_IRQ_EN defined, irq_pend SHALL be a register that follows cmd_pend one cycle late, and irq_o=irq_pend.
REQ-028 Without TWPM_WB_IRQ_EN, irq_o SHALL be 0, STATUS bit3 SHALL read 0, and the port SHALL remain present.

Verification
REQ-029 Write 0xA5A5_0001 with BYTE_STB=4'b0011 to 0x00010 -> ram_wr_en pulse, ram_a=4, ram_wen=0011, ACK one cycle later.
REQ-030 Read 0x00010 with ram_rd=0xDEADBEEF -> ram_rd_en in the request cycle, ACK two cycles later with WBs_RD_DAT=0xDEADBEEF.
REQ-031 Raise exec_i -> within 3 cycles STATUS=0x5 (0xD with TWPM_WB_IRQ_EN) and COUNT=1. Then write 0x1 to CONTROL (0x10008) -> complete_o=1. Then drop exec_i -> complete_o=0 within 4 cycles.
REQ-032 Preload cnt=0xFFFF and pulse exec_i -> COUNT reads 0x0000.
REQ-033 Exec rising edge in the same cycle as a CONTROL clear (0x2) -> cmd_pend remains 1. An abort_i rise then clears it.
REQ-034 Assert WB_RST during RD_WAIT -> no ACK, all outputs 0 next cycle, and a next read completes normally.
